instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-005 imem_addr  output  32  byte address of the outstanding fetch.
REQ-006 imem_ack  input  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr_valid  output  1  held instruction available to the decode/controller stage.
REQ-009 instr_ready  input  1  decode/datapath accepts the held instruction this cycle.
REQ-010 instr  output  32  held instruction word.
REQ-011 opcode  output  6  instr[31:26], feeds the controller opcode input.
REQ-012 func  output  6  instr[5:0], feeds the controller func input.
REQ-013 pc  output  32  byte address of the held instruction.
REQ-014 branch_taken  input  1  controller Branch AND ALU zero for the held instruction.
REQ-015 branch_offset  input  16  signed word offset (instr immediate) for a taken branch.
REQ-016 retire_count  output  32  number of instructions accepted since reset.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, FETCH, HOLD.
REQ-018 IDLE: imem_req=0, instr_valid=0; SHALL go to FETCH on the next edge unconditionally.
REQ-019 FETCH: imem_req=1, imem_addr=fetch_addr register; instr_valid=0; on imem_ack=1 SHALL capture imem_rdata into instr, load pc with fetch_addr and go to HOLD.
REQ-020 FETCH with imem_ack=0 SHALL remain in FETCH with imem_addr unchanged (no request withdrawal).
REQ-021 HOLD: imem_req=0, instr_valid=1; instr, opcode, func, pc SHALL stay stable until acceptance.
REQ-022 HOLD with instr_ready=1 (acceptance) SHALL go to FETCH, increment retire_count and load fetch_addr with next_pc.
REQ-023 next_pc SHALL be pc+4 when branch_taken=0, and pc+4+(sign_extend(branch_offset)<<2) when branch_taken=1, all modulo 2^32.
REQ-024 branch_taken and branch_offset SHALL be sampled only on the acceptance cycle and ignored otherwise.
REQ-025 imem_ack in IDLE or HOLD SHALL be ignored (no state, instr or pc change).
REQ-026 Latency: ack in cycle N SHALL give instr_valid=1 in cycle N+1; acceptance in cycle M SHALL give imem_req=1 in cycle M+1 with the new address.
REQ-027 Sustained throughput with single-cycle ack and instr_ready held high SHALL be one instruction per two cycles.
REQ-028 pc and fetch_addr SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error; backward branches SHALL wrap below zero likewise.
REQ-029 retire_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 opcode and func SHALL be purely combinational slices of instr.

Reset
REQ-031 rst=1 SHALL immediately (asynchronously) force state=IDLE, imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, fetch_addr=RESET_PC, retire_count=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the request; a late imem_ack after reset SHALL be ignored and the first post-reset fetch SHALL be at RESET_PC.
REQ-033 Outputs SHALL hold reset values for as long as rst=1; the first imem_req SHALL occur in the second cycle after rst deasserts.

Verification
REQ-034 Reset release, ack=1 every cycle, ready=1 -> imem_addr sequence 0,4,8,C; instr_valid every other cycle; retire_count=4 after 8 cycles.
REQ-035 Fetch of word 32'h0000_0002 at pc=0x10 -> opcode=0, func=2, pc=0x10 while HOLD; ready=0 for 5 cycles -> outputs unchanged, no imem_req.
REQ-036 pc=0x20, ready=1, branch_taken=1, branch_offset=16'hFFFE -> next imem_addr=0x1C; branch_offset=16'h0003 with branch_taken=0 -> 0x24.
REQ-037 imem_ack held low 4 cycles in FETCH -> imem_req=1 and imem_addr constant; ack pulse in HOLD -> instr unchanged.
REQ-038 RESET_PC=32'hFFFF_FFFC, one accept -> next imem_addr=0x0000_0000.
REQ-039 rst asserted mid-FETCH at addr 0x40, ack arriving during rst -> imem_req=0 immediately; after release first imem_addr=RESET_PC, retire_count=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode handoff and branch feedback.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] retire_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, func, pc, retire_count,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, func, pc, retire_count,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: request a word, hold it for decode, then
// advance to pc+4 or a branch target on acceptance.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] fetch_addr;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] retire_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] branch_disp;
    logic [31:0] next_pc;

    // Word offset scaled to bytes; the add below wraps modulo 2^32 in both directions.
    assign branch_disp = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign next_pc     = pc_q + 32'd4 + (bus.branch_taken ? branch_disp : 32'd0);

    // NOTE: state registers use non-blocking assignment so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            pc_q       <= RESET_PC;
            fetch_addr <= RESET_PC;
            retire_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        pc_q    <= fetch_addr;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // Branch inputs only matter on the acceptance edge.
                    if (bus.instr_ready) begin
                        fetch_addr <= next_pc;
                        retire_q   <= retire_q + 32'd1;
                        valid_q    <= 1'b0;
                        req_q      <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = fetch_addr;
    assign bus.instr_valid  = valid_q;
    assign bus.instr        = instr_q;
    assign bus.opcode       = instr_q[31:26];
    assign bus.func         = instr_q[5:0];
    assign bus.pc           = pc_q;
    assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run against a transaction-level model of the fetch/hold/accept rules.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch_if bus_w ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    int n_cmp = 0;
    int n_err = 0;

    // Outputs are observed 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus.imem_ack = 1'b0;     bus.imem_rdata = 32'd0;    bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_offset = 16'd0;
        bus_w.imem_ack = 1'b0;   bus_w.imem_rdata = 32'd0;  bus_w.instr_ready = 1'b0;
        bus_w.branch_taken = 1'b0; bus_w.branch_offset = 16'd0;
    endtask

    task automatic apply_reset();
        drive_quiet();
        rst = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic goto_fetch(input logic [31:0] target);
        bit found = 1'b0;
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.branch_taken = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (bus.imem_req === 1'b1 && bus.imem_addr === target) found = 1'b1;
            else step();
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL goto_fetch: addr %h never requested, last imem_addr %h", target, bus.imem_addr);
        end
    endtask

    task automatic test_reset();
        drive_quiet();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'd0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
        n_cmp++; if (bus.pc !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
        n_cmp++; if (bus.imem_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.retire_count !== 32'd0) begin n_err++; $display("FAIL reset_retire: got %h want 0", bus.retire_count); end
        n_cmp++; if (bus_w.pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_pc_param: got %h want fffffffc", bus_w.pc); end
        n_cmp++; if (bus_w.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_addr_param: got %h want fffffffc", bus_w.imem_addr); end
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_held: req %b valid %b want 0 0", bus.imem_req, bus.instr_valid); end
        end
        rst = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL release_idle: req %b want 0", bus.imem_req); end
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
            n_err++; $display("FAIL first_req: req %b addr %h want 1 00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_throughput();
        logic [31:0] last;
        last = 32'd0;
        apply_reset();
        step();
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                n_cmp++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'(i * 2)) begin
                    n_err++; $display("FAIL tput_fetch[%0d]: req %b valid %b addr %h want 1 0 %h",
                                      i, bus.imem_req, bus.instr_valid, bus.imem_addr, 32'(i * 2)); end
                last = $urandom;
                bus.imem_rdata = last;
            end else begin
                n_cmp++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== last || bus.pc !== 32'((i - 1) * 2)) begin
                    n_err++; $display("FAIL tput_hold[%0d]: valid %b req %b instr %h pc %h want 1 0 %h %h",
                                      i, bus.instr_valid, bus.imem_req, bus.instr, bus.pc, last, 32'((i - 1) * 2)); end
            end
            step();
        end
        n_cmp++; if (bus.retire_count !== 32'd4 || bus.imem_addr !== 32'h10) begin
            n_err++; $display("FAIL tput_retire: retire %0d addr %h want 4 00000010", bus.retire_count, bus.imem_addr); end
    endtask

    task automatic test_hold_stall();
        goto_fetch(32'h10);
        bus.imem_rdata = 32'h0000_0002; bus.instr_ready = 1'b0;
        step();
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 6'd0 || bus.func !== 6'd2 || bus.pc !== 32'h10 || bus.instr !== 32'd2) begin
            n_err++; $display("FAIL hold_fields: valid %b opcode %h func %h pc %h instr %h want 1 00 02 00000010 00000002",
                              bus.instr_valid, bus.opcode, bus.func, bus.pc, bus.instr); end
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = $urandom | 32'h8000_0001;
            bus.branch_taken = 1'b1; bus.branch_offset = 16'($urandom);
            step();
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== 32'd2 || bus.pc !== 32'h10 ||
                         bus.opcode !== 6'd0 || bus.func !== 6'd2 || bus.retire_count !== 32'd4) begin
                n_err++; $display("FAIL hold_stable[%0d]: valid %b req %b instr %h pc %h retire %0d want 1 0 00000002 00000010 4",
                                  i, bus.instr_valid, bus.imem_req, bus.instr, bus.pc, bus.retire_count); end
        end
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b0;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14 || bus.instr_valid !== 1'b0 || bus.retire_count !== 32'd5) begin
            n_err++; $display("FAIL hold_accept: req %b addr %h valid %b retire %0d want 1 00000014 0 5",
                              bus.imem_req, bus.imem_addr, bus.instr_valid, bus.retire_count); end
    endtask

    task automatic test_branch();
        goto_fetch(32'h20);
        bus.instr_ready = 1'b0;
        bus.branch_taken = 1'b1; bus.branch_offset = 16'h7FFF;
        step();
        n_cmp++; if (bus.pc !== 32'h20 || bus.instr_valid !== 1'b1) begin
            n_err++; $display("FAIL branch_hold: pc %h valid %b want 00000020 1", bus.pc, bus.instr_valid); end
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFE;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1C) begin
            n_err++; $display("FAIL branch_back: req %b addr %h want 1 0000001c", bus.imem_req, bus.imem_addr); end
        goto_fetch(32'h20);
        bus.instr_ready = 1'b0;
        step();
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b0; bus.branch_offset = 16'h0003;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
            n_err++; $display("FAIL branch_not_taken: req %b addr %h want 1 00000024", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_ack_stall();
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.imem_rdata = $urandom;
            step();
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24 || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL ack_stall[%0d]: req %b addr %h valid %b want 1 00000024 0",
                                  i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.instr_ready = 1'b0;
        step();
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        n_cmp++; if (bus.instr !== 32'h1234_5678 || bus.pc !== 32'h24 || bus.instr_valid !== 1'b1) begin
            n_err++; $display("FAIL ack_in_hold: instr %h pc %h valid %b want 12345678 00000024 1",
                              bus.instr, bus.pc, bus.instr_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus_w.imem_ack = 1'b1; bus_w.instr_ready = 1'b0;
        step();
        n_cmp++; if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_first: req %b addr %h want 1 fffffffc", bus_w.imem_req, bus_w.imem_addr); end
        step();
        n_cmp++; if (bus_w.pc !== 32'hFFFF_FFFC || bus_w.instr_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_hold: pc %h valid %b want fffffffc 1", bus_w.pc, bus_w.instr_valid); end
        bus_w.instr_ready = 1'b1;
        step();
        n_cmp++; if (bus_w.imem_addr !== 32'h0 || bus_w.imem_req !== 1'b1 || bus_w.retire_count !== 32'd1) begin
            n_err++; $display("FAIL wrap_next: addr %h req %b retire %0d want 00000000 1 1",
                              bus_w.imem_addr, bus_w.imem_req, bus_w.retire_count); end
        drive_quiet();
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        step();
        goto_fetch(32'h40);
        bus.imem_ack = 1'b0;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            n_err++; $display("FAIL mid_fetch_pre: req %b addr %h want 1 00000040", bus.imem_req, bus.imem_addr); end
        #2;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd0) begin
            n_err++; $display("FAIL mid_fetch_async: req %b valid %b addr %h want 0 0 00000000",
                              bus.imem_req, bus.instr_valid, bus.imem_addr); end
        step();
        rst = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.retire_count !== 32'd0 || bus.pc !== 32'd0 || bus.instr !== 32'd0) begin
            n_err++; $display("FAIL mid_fetch_release: req %b retire %0d pc %h instr %h want 0 0 00000000 00000000",
                              bus.imem_req, bus.retire_count, bus.pc, bus.instr); end
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0 || bus.instr_valid !== 1'b0 || bus.retire_count !== 32'd0) begin
            n_err++; $display("FAIL mid_fetch_refetch: req %b addr %h valid %b retire %0d want 1 00000000 0 0",
                              bus.imem_req, bus.imem_addr, bus.instr_valid, bus.retire_count); end
        bus.imem_ack = 1'b0;
        step();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_fetch_late_ack: req %b valid %b want 1 0", bus.imem_req, bus.instr_valid); end
    endtask

    // Transaction-level model: an instruction is either being fetched or waiting for decode.
    task automatic test_random();
        bit                 fetching;
        logic [31:0]        exp_addr, exp_instr, exp_pc, exp_retire;
        logic signed [31:0] disp;
        apply_reset();
        step();
        fetching = 1'b1; exp_addr = 32'd0; exp_instr = 32'd0; exp_pc = 32'd0; exp_retire = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (fetching) begin
                n_cmp++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== exp_addr) begin
                    n_err++; $display("FAIL rand_fetch[%0d]: req %b valid %b addr %h want 1 0 %h",
                                      c, bus.imem_req, bus.instr_valid, bus.imem_addr, exp_addr); end
            end else begin
                n_cmp++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== exp_instr || bus.pc !== exp_pc ||
                             bus.opcode !== exp_instr[31:26] || bus.func !== exp_instr[5:0]) begin
                    n_err++; $display("FAIL rand_hold[%0d]: valid %b req %b instr %h pc %h opc %h func %h want 1 0 %h %h",
                                      c, bus.instr_valid, bus.imem_req, bus.instr, bus.pc, bus.opcode, bus.func, exp_instr, exp_pc); end
            end
            n_cmp++; if (bus.retire_count !== exp_retire) begin
                n_err++; $display("FAIL rand_retire[%0d]: got %0d want %0d", c, bus.retire_count, exp_retire); end
            bus.imem_ack      = 1'($urandom_range(0, 1));
            bus.imem_rdata    = $urandom;
            bus.instr_ready   = 1'($urandom_range(0, 1));
            bus.branch_taken  = 1'($urandom_range(0, 1));
            bus.branch_offset = 16'($urandom);
            if (fetching && bus.imem_ack) begin
                fetching  = 1'b0;
                exp_instr = bus.imem_rdata;
                exp_pc    = exp_addr;
            end else if (!fetching && bus.instr_ready) begin
                if (bus.branch_taken) disp = $signed(bus.branch_offset);
                else disp = 0;
                exp_addr   = exp_pc + 32'd4 + 32'(disp * 4);
                exp_retire = exp_retire + 32'd1;
                fetching   = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_hold_stall();
        test_branch();
        test_ack_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched so far", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
